// File: rtl/cuckoo_pkg.sv
// Shared constants, FSM state type and nibble-XOR index hash for the cuckoo insert stages.
// Defining CUCKOO_STASH_EN widens the occupancy count to cover the stash entries.
package cuckoo_pkg;
    localparam int unsigned TBL_DEPTH   = 16;
    localparam int unsigned IDX_W       = 4;
    localparam int unsigned KICK_W      = 4;
    localparam int unsigned STASH_DEPTH = 4;
    localparam int unsigned HASH_MAX_W  = 64;
`ifdef CUCKOO_STASH_EN
    localparam int unsigned OCC_W = 6;
`else
    localparam int unsigned OCC_W = 5;
`endif

    typedef enum logic [1:0] {StIdle, StProbe, StKick, StFail} cuckoo_state_e;

    // Callers zero-extend keys to HASH_MAX_W; the padding nibbles XOR in as zero.
    function automatic logic [IDX_W-1:0] cuckoo_idx(input logic [HASH_MAX_W-1:0] key);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(HASH_MAX_W / IDX_W); i++) begin
            idx ^= key[i*IDX_W +: IDX_W];
        end
        return idx;
    endfunction
endpackage

// File: rtl/cuckoo_t2_mem.sv
// Table-2 storage: 16 entries of key plus valid bit, combinational read,
// single synchronous write port and synchronous clear.
module cuckoo_t2_mem
    import cuckoo_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_key,
    output logic             rd_valid,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_key
);
    logic [WIDTH-1:0]     key_q [TBL_DEPTH];
    logic [TBL_DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
            for (int i = 0; i < int'(TBL_DEPTH); i++) begin
                key_q[i] <= '0;
            end
        end else if (we) begin
            key_q[wr_idx]   <= wr_key;
            valid_q[wr_idx] <= 1'b1;
        end
    end

    assign rd_key   = key_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];
endmodule

// File: rtl/cuckoo_t2_insert.sv
// Table-2 insert stage of a two-table cuckoo hash: place, dedupe, displace or reject a key.
// Optional CUCKOO_STASH_EN adds a 4-entry stash that absorbs keys over the kick limit.
module cuckoo_t2_insert
    import cuckoo_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_KICKS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_key,
    input  logic [KICK_W-1:0] in_kicks,
    output logic              kick_valid,
    input  logic              kick_ready,
    output logic [WIDTH-1:0]  kick_key,
    output logic [KICK_W-1:0] kick_cnt,
    output logic              done,
    output logic              dup,
    output logic              fail,
    output logic [WIDTH-1:0]  fail_key,
    output logic [OCC_W-1:0]  occupancy
);
    // A limit of 16 or more can never be exceeded by a 4-bit count plus one.
    localparam logic [KICK_W:0] KICK_LIMIT = (MAX_KICKS >= 16) ? 5'd16 : 5'(MAX_KICKS);

    cuckoo_state_e     state_q;
    logic [WIDTH-1:0]  key_q, kick_key_q, fail_key_q;
    logic [KICK_W-1:0] kicks_q, kick_cnt_q;
    logic              kick_valid_q, done_q, dup_q, fail_q;
    logic [OCC_W-1:0]  occ_q;

    logic [IDX_W-1:0]  idx;
    logic [WIDTH-1:0]  rd_key;
    logic              rd_valid, hit, kick_ok, mem_we;
    logic [KICK_W:0]   kicks_inc;
    logic [KICK_W-1:0] sat_cnt;

    assign idx       = cuckoo_idx(HASH_MAX_W'(key_q));
    assign hit       = rd_valid && (rd_key == key_q);
    assign kicks_inc = {1'b0, kicks_q} + 5'd1;
    assign sat_cnt   = kicks_inc[KICK_W] ? '1 : kicks_inc[KICK_W-1:0];
    assign kick_ok   = kicks_inc <= KICK_LIMIT;
    assign mem_we    = (state_q == StProbe) && !rst && (!rd_valid || (!hit && kick_ok));

    cuckoo_t2_mem #(
        .WIDTH(WIDTH)
    ) u_mem (
        .clk     (clk),
        .clear   (rst),
        .rd_idx  (idx),
        .rd_key  (rd_key),
        .rd_valid(rd_valid),
        .we      (mem_we),
        .wr_idx  (idx),
        .wr_key  (key_q)
    );

`ifdef CUCKOO_STASH_EN
    logic [WIDTH-1:0]       stash_key_q [STASH_DEPTH];
    logic [STASH_DEPTH-1:0] stash_vld_q;
    logic [1:0]             stash_slot;
    logic                   stash_full;

    assign stash_full = &stash_vld_q;

    always_comb begin
        stash_slot = '0;
        for (int i = int'(STASH_DEPTH) - 1; i >= 0; i--) begin
            if (!stash_vld_q[i]) stash_slot = 2'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            key_q        <= '0;
            kicks_q      <= '0;
            kick_valid_q <= 1'b0;
            kick_key_q   <= '0;
            kick_cnt_q   <= '0;
            done_q       <= 1'b0;
            dup_q        <= 1'b0;
            fail_q       <= 1'b0;
            fail_key_q   <= '0;
            occ_q        <= '0;
`ifdef CUCKOO_STASH_EN
            stash_vld_q  <= '0;
            for (int i = 0; i < int'(STASH_DEPTH); i++) begin
                stash_key_q[i] <= '0;
            end
`endif
        end else begin
            done_q <= 1'b0;
            dup_q  <= 1'b0;
            fail_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        key_q   <= in_key;
                        kicks_q <= in_kicks;
                        state_q <= StProbe;
                    end
                end
                StProbe: begin
                    if (!rd_valid) begin
                        occ_q   <= occ_q + OCC_W'(1);
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (hit) begin
                        dup_q   <= 1'b1;
                        state_q <= StIdle;
                    end else if (kick_ok) begin
                        kick_key_q   <= rd_key;
                        kick_cnt_q   <= sat_cnt;
                        kick_valid_q <= 1'b1;
                        state_q      <= StKick;
                    end else begin
                        fail_key_q <= key_q;
`ifdef CUCKOO_STASH_EN
                        fail_q     <= stash_full;
`else
                        fail_q     <= 1'b1;
`endif
                        state_q    <= StFail;
                    end
                end
                StKick: begin
                    if (kick_ready) begin
                        kick_valid_q <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                StFail: begin
`ifdef CUCKOO_STASH_EN
                    if (!stash_full) begin
                        stash_key_q[stash_slot] <= fail_key_q;
                        stash_vld_q[stash_slot] <= 1'b1;
                        occ_q                   <= occ_q + OCC_W'(1);
                        done_q                  <= 1'b1;
                    end
`endif
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready   = (state_q == StIdle) && !rst;
    assign kick_valid = kick_valid_q;
    assign kick_key   = kick_key_q;
    assign kick_cnt   = kick_cnt_q;
    assign done       = done_q;
    assign dup        = dup_q;
    assign fail       = fail_q;
    assign fail_key   = fail_key_q;
    assign occupancy  = occ_q;
endmodule

// File: tb/tb_cuckoo_t2_insert.sv
// Scoreboard bench for cuckoo_t2_insert: a reference table model predicts each
// insert's outcome, and the observed pulse/kick is popped and compared.
module tb_cuckoo_t2_insert;
    localparam int W  = 32;
    localparam int MK = 8;
`ifdef CUCKOO_STASH_EN
    localparam int OW = 6;
`else
    localparam int OW = 5;
`endif

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, kick_valid, kick_ready, done, dup, fail;
    logic [W-1:0]  in_key, kick_key, fail_key;
    logic [3:0]    in_kicks, kick_cnt;
    logic [OW-1:0] occupancy;

    always #5 clk = ~clk;

    cuckoo_t2_insert #(
        .WIDTH    (W),
        .MAX_KICKS(MK)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_kicks  (in_kicks),
        .kick_valid(kick_valid),
        .kick_ready(kick_ready),
        .kick_key  (kick_key),
        .kick_cnt  (kick_cnt),
        .done      (done),
        .dup       (dup),
        .fail      (fail),
        .fail_key  (fail_key),
        .occupancy (occupancy)
    );

    typedef enum int {EDone, EDup, EKick, EFail, ENone} kind_t;
    typedef struct {
        kind_t      kind;
        logic [W-1:0] key;
        logic [3:0] cnt;
        int         lat;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_key[16];
    bit           m_vld[16];
    int           m_occ;
    int           m_stash;
    int           checks = 0;
    int           errors = 0;

    function automatic int tb_idx(input logic [W-1:0] k);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < W / 4; i++) r = r ^ k[i*4 +: 4];
        return int'(r);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_vld[i] = 1'b0;
            m_key[i] = '0;
        end
        m_occ   = 0;
        m_stash = 0;
        sb.delete();
    endfunction

    function automatic void predict(input logic [W-1:0] k, input logic [3:0] kc);
        exp_t e;
        int   ix;
        int   nk;
        ix    = tb_idx(k);
        nk    = int'(kc) + 1;
        e.key = k;
        e.cnt = 4'h0;
        e.lat = 1;
        if (!m_vld[ix]) begin
            e.kind    = EDone;
            m_vld[ix] = 1'b1;
            m_key[ix] = k;
            m_occ++;
        end else if (m_key[ix] == k) begin
            e.kind = EDup;
        end else if (nk <= MK) begin
            e.kind    = EKick;
            e.key     = m_key[ix];
            e.cnt     = (nk > 15) ? 4'd15 : 4'(nk);
            m_key[ix] = k;
        end else begin
`ifdef CUCKOO_STASH_EN
            if (m_stash < 4) begin
                e.kind = EDone;
                e.lat  = 2;
                m_stash++;
                m_occ++;
            end else begin
                e.kind = EFail;
            end
`else
            e.kind = EFail;
`endif
        end
        sb.push_back(e);
    endfunction

    // Present one key; returns after the accepting edge with in_valid dropped.
    task automatic send(input logic [W-1:0] k, input logic [3:0] kc);
        int n;
        predict(k, kc);
        in_valid = 1'b1;
        in_key   = k;
        in_kicks = kc;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready key=%h: in_ready=%b required 1", k, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for the outcome of the oldest outstanding insert and compare it.
    task automatic expect_result(input int hold);
        exp_t  e;
        kind_t k;
        int    cyc;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: 0 entries, required 1");
            return;
        end
        e   = sb.pop_front();
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!(done || dup || fail || kick_valid) && cyc < 20);
        k = done ? EDone : dup ? EDup : fail ? EFail : kick_valid ? EKick : ENone;
        if (k !== e.kind) begin
            errors++;
            $display("FAIL outcome: got %s required %s", k.name(), e.kind.name());
        end
        checks++;
        if (cyc != e.lat) begin
            errors++;
            $display("FAIL latency: got %0d required %0d", cyc, e.lat);
        end
        if (k == EKick) begin
            checks++;
            if (e.kind == EKick && (kick_key !== e.key || kick_cnt !== e.cnt)) begin
                errors++;
                $display("FAIL kick_data: key=%h cnt=%0d required key=%h cnt=%0d",
                         kick_key, kick_cnt, e.key, e.cnt);
            end
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                checks++;
                if (kick_valid !== 1'b1 || kick_key !== e.key || kick_cnt !== e.cnt ||
                    in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL kick_hold[%0d]: v=%b key=%h cnt=%0d rdy=%b required 1 %h %0d 0",
                             i, kick_valid, kick_key, kick_cnt, in_ready, e.key, e.cnt);
                end
            end
            kick_ready = 1'b1;
            @(posedge clk);
            #1;
            kick_ready = 1'b0;
            checks++;
            if (done !== 1'b1 || kick_valid !== 1'b0) begin
                errors++;
                $display("FAIL kick_done: done=%b kick_valid=%b required 1 0", done, kick_valid);
            end
        end
        if (k == EFail) begin
            checks++;
            if (fail_key !== e.key) begin
                errors++;
                $display("FAIL fail_key: got %h required %h", fail_key, e.key);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || dup !== 1'b0 || fail !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pulse_end: done=%b dup=%b fail=%b in_ready=%b required 0 0 0 1",
                     done, dup, fail, in_ready);
        end
    endtask

    task automatic check_occ(input string tag);
        checks++;
        if (int'(occupancy) != m_occ) begin
            errors++;
            $display("FAIL occupancy_%s: got %0d required %0d", tag, occupancy, m_occ);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || kick_valid !== 1'b0 || done !== 1'b0 || dup !== 1'b0 ||
            fail !== 1'b0 || occupancy !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b kv=%b done=%b dup=%b fail=%b occ=%0d required all 0",
                     in_ready, kick_valid, done, dup, fail, occupancy);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
        model_clear();
    endtask

    task automatic test_insert_empty();
        send(32'h12, 4'd0);
        expect_result(0);
        check_occ("empty");
        checks++;
        if (kick_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_no_kick: kick_valid=%b required 0", kick_valid);
        end
    endtask

    task automatic test_dup();
        send(32'h12, 4'd0);
        expect_result(0);
        check_occ("dup");
    endtask

    task automatic test_kick();
        send(32'h21, 4'd2);
        expect_result(5);
        check_occ("kick");
        send(32'h21, 4'd0);
        expect_result(0);
    endtask

    task automatic test_fail();
        send(32'h30, 4'd8);
        expect_result(0);
        check_occ("fail");
        send(32'h21, 4'd0);
        expect_result(0);
    endtask

    task automatic test_rst_kick();
        exp_t e;
        int   n;
        send(32'h03, 4'd0);
        e = sb.pop_front();
        n = 0;
        while (!kick_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (kick_valid !== 1'b1 || kick_key !== e.key || kick_cnt !== e.cnt) begin
            errors++;
            $display("FAIL rst_kick_pre: v=%b key=%h cnt=%0d required 1 %h %0d",
                     kick_valid, kick_key, kick_cnt, e.key, e.cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (kick_valid !== 1'b0 || occupancy !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_kick: kv=%b occ=%0d rdy=%b required 0 0 0",
                     kick_valid, occupancy, in_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_kick_ready: in_ready=%b required 1", in_ready);
        end
        model_clear();
        send(32'h21, 4'd0);
        expect_result(0);
        check_occ("after_rst");
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            send(W'(i), 4'd0);
            expect_result(0);
        end
        check_occ("full");
        checks++;
        if (occupancy !== OW'(16)) begin
            errors++;
            $display("FAIL full_16: occupancy=%0d required 16", occupancy);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            send(W'(32'hA0 + i), 4'd7);
            expect_result(0);
            check_occ("b2b");
        end
        send(32'h5A5, 4'd8);
        expect_result(0);
        check_occ("full_fail");
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_key     = '0;
        in_kicks   = '0;
        kick_ready = 1'b0;
        model_clear();
        test_reset();
        test_insert_empty();
        test_dup();
        test_kick();
        test_fail();
        test_rst_kick();
        test_fill();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
